sq_qpn_scheduler: RTL and testbench
===================================

# sq_qpn_scheduler

Round-robin scheduler sharing the SQ metadata pipeline's single QPN input among several doorbell sources (host doorbell, retransmit, timer requeue, etc.). It arbitrates between requesters, registers the winning QPN into a one-entry output slot toward the SQ metadata processor, and caps the number of QPNs in flight through context/MR fetch with a credit counter. Credits are returned by a completion pulse issued when the metadata processor hands `sq_meta` to WQE fetch.

## Interface
- `REQ_NUM`, default 4: number of requester channels; allowed range 2..8.
- `MAX_INFLIGHT`, default 8: maximum QPNs accepted but not yet completed; allowed range 1..255.
- `CNT_W`, default `$clog2(MAX_INFLIGHT+1)`: width of the in-flight counter.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sched_enable`  in  1  when low, no new grants are issued; the output slot still drains.
- `req_valid`  in  REQ_NUM  per-requester request valid.
- `req_qpn`  in  REQ_NUM*24  per-requester QPN; requester i occupies bits [24i+23:24i].
- `req_ready`  out  REQ_NUM  one-hot grant/accept; at most one bit is high per cycle.
- `qpn_valid`  out  1  QPN valid toward the metadata processor.
- `qpn_data`  out  24  registered QPN.
- `qpn_ready`  in  1  metadata processor accepts the QPN.
- `meta_done`  in  1  single-cycle pulse per completed QPN; returns one credit.
- `inflight_cnt`  out  CNT_W  current credit usage.
- `credit_err`  out  1  sticky flag: `meta_done` was received while `inflight_cnt` = 0.

## Operation
- **Output slot.** States are EMPTY and FULL, tracked by `qpn_valid`.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `qpn_valid & qpn_ready` with no same-cycle grant.
  - FULL→FULL when a drain and a grant occur in the same cycle.
- **Grant condition.** A grant is issued when all of the following hold:
  - `sched_enable` = 1;
  - the slot is EMPTY, or it is draining this cycle (`qpn_ready` = 1);
  - `inflight_cnt` < `MAX_INFLIGHT`;
  - at least one `req_valid` is asserted.
- **Arbitration.**
  - Winner: the first index with `req_valid` high, scanning from `rr_ptr` upward with wrap at `REQ_NUM`-1→0.
  - `req_ready[winner]` is asserted combinationally in the grant cycle, so the handshake is `req_valid & req_ready`.
  - `qpn_data` <= `req_qpn[winner]`.
  - `rr_ptr` <= winner+1, mod `REQ_NUM`.
  - `rr_ptr` is unchanged in cycles with no grant.
- **Requester rule.** A requester holds `req_valid` and `req_qpn` stable until granted. `req_ready` never depends on that requester's own `req_valid` being removed.
- **Credits.**
  - A grant increments `inflight_cnt`.
  - `meta_done` decrements it.
  - A grant and `meta_done` in the same cycle leave it unchanged.
  - `meta_done` at 0 leaves the count at 0 and sets `credit_err`. `credit_err` clears only on reset.
- **Counter width.** `inflight_cnt` never exceeds `MAX_INFLIGHT` and never wraps. Ready and credit checks are purely combinational and are done at `CNT_W` width.
- **Deasserting `sched_enable`.** Takes effect the same cycle: no `req_ready`. A QPN already in the slot stays valid until accepted.
- **Reset mid-operation.** A QPN held in the slot is dropped and all credits are forgotten. Upstream and downstream blocks are reset in the same domain, so nothing reconciles them.

## Timing
- Reset values: `qpn_valid`=0, `qpn_data`=0, `req_ready`=0 (combinational, gated by the reset state), `inflight_cnt`=0, `credit_err`=0, `rr_ptr`=0.
- Latency: grant in cycle N → `qpn_valid`=1 with the QPN in cycle N+1.
- Throughput: with `qpn_ready` held high and credits available, one QPN per cycle with no bubbles.
- `qpn_valid` and `qpn_data` are held stable while `qpn_ready`=0.
- Credit effects:
  - A credit returned by `meta_done` in cycle N allows a grant in cycle N+1, not N.
  - A grant in cycle N is visible in `inflight_cnt` in cycle N+1.
- No combinational path from `qpn_ready` to `qpn_valid`. `req_ready` depends combinationally on `qpn_ready`, `req_valid`, `rr_ptr`, `inflight_cnt` and `sched_enable`.

## Test plan
- **Reset check.** Hold `rst`=0 with all `req_valid`=1 → `req_ready`=0, `qpn_valid`=0, `inflight_cnt`=0. Release reset → first grant to requester 0; QPN appears the next cycle.
- **Round robin.** All 4 requesters valid with QPNs 0x10/0x20/0x30/0x40, `qpn_ready`=1, `MAX_INFLIGHT`=8 → `qpn_data` sequence 0x10,0x20,0x30,0x40 on consecutive cycles; with `meta_done` tied high the order then restarts at 0x10.
- **Sparse requesters.** Only requesters 1 and 3 valid, `rr_ptr`=2 → grant order 3,1,3,1; requesters 0 and 2 never see `req_ready`.
- **Credit cap.** `MAX_INFLIGHT`=8, no `meta_done` → exactly 8 grants, then `req_ready`=0 with `inflight_cnt`=8. One `meta_done` pulse in cycle N → exactly one grant in cycle N+1 and `inflight_cnt` returns to 8.
- **Backpressure.** `qpn_ready`=0 for 5 cycles with the slot FULL → `qpn_data` stable and no `req_ready`. Raise `qpn_ready` → drain and next grant occur in the same cycle.
- **Credit edge cases.** Grant coincident with `meta_done` → `inflight_cnt` unchanged. `meta_done` at count 0 → count stays 0 and `credit_err`=1 until reset.

Source files
------------

// File: rtl/sq_qpn_scheduler.sv
// Round-robin scheduler that funnels several doorbell sources (host doorbell,
// retransmit, timer requeue, ...) into the single QPN input of the SQ metadata
// pipeline. The winning QPN is registered into a one-entry output slot. A
// credit counter caps how many QPNs are in flight through context/MR fetch.
module sq_qpn_scheduler #(
  parameter int REQ_NUM      = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sched_enable,
  input  logic [REQ_NUM-1:0]    req_valid,
  input  logic [REQ_NUM*24-1:0] req_qpn,
  output logic [REQ_NUM-1:0]    req_ready,
  output logic                  qpn_valid,
  output logic [23:0]           qpn_data,
  input  logic                  qpn_ready,
  input  logic                  meta_done,
  output logic [CNT_W-1:0]      inflight_cnt,
  output logic                  credit_err
);

  localparam int               PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(REQ_NUM - 1);

  // The output slot is either holding a QPN for the metadata processor or not.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      slot_state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  logic             any_valid;
  logic             slot_open;
  logic             credit_ok;
  logic             grant;
  logic [23:0]      qpn_array [REQ_NUM];

  // Unpack the flat QPN bus into one 24-bit lane per requester.
  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign qpn_array[gi] = req_qpn[24*gi +: 24];
    end
  endgenerate

  // Pick the first valid requester at or above rr_ptr, wrapping at REQ_NUM-1.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % REQ_NUM);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign any_valid = |req_valid;
  // The slot can take a new QPN if empty, or if it is being drained right now.
  assign slot_open = (slot_state == SLOT_EMPTY) || qpn_ready;
  // Credit check done at counter width; count can never exceed MAX_CNT.
  assign credit_ok = (inflight_cnt < MAX_CNT);
  // rst gates the grant so req_ready stays low while reset is held.
  assign grant     = rst && sched_enable && slot_open && credit_ok && any_valid;
  assign next_ptr  = (winner == LAST_IX) ? '0 : winner + PTR_W'(1);

  // One-hot accept toward the winning requester only.
  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_ready
      assign req_ready[gi] = grant && (winner == PTR_W'(gi));
    end
  endgenerate

  assign qpn_valid = (slot_state == SLOT_FULL);

  // Output slot FSM: load on grant, release on accept without a refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_state <= SLOT_EMPTY;
      qpn_data   <= '0;
    end else begin
      case (slot_state)
        SLOT_EMPTY: begin
          if (grant) begin
            slot_state <= SLOT_FULL;
            qpn_data   <= qpn_array[winner];
          end
        end
        SLOT_FULL: begin
          if (grant) begin
            slot_state <= SLOT_FULL;
            qpn_data   <= qpn_array[winner];
          end else if (qpn_ready) begin
            slot_state <= SLOT_EMPTY;
          end
        end
        default: slot_state <= SLOT_EMPTY;
      endcase
    end
  end

  // Advance the round-robin pointer past the winner only when a grant happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // Credit accounting: grants consume, meta_done returns; underflow is flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_cnt <= '0;
      credit_err   <= 1'b0;
    end else if (meta_done && (inflight_cnt == '0)) begin
      // A return with nothing outstanding is a protocol error; count holds at 0.
      credit_err <= 1'b1;
    end else if (grant && !meta_done) begin
      inflight_cnt <= inflight_cnt + CNT_W'(1);
    end else if (!grant && meta_done) begin
      inflight_cnt <= inflight_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sq_qpn_scheduler.sv
// Self-checking bench for sq_qpn_scheduler: a cycle model derived from the
// scheduling rules is compared against the DUT on every falling edge, and
// directed scenarios pin grant orders and counts to hand-computed values.
module tb_sq_qpn_scheduler;

  localparam int N    = 4;
  localparam int MAXI = 8;
  localparam int CW   = $clog2(MAXI + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sched_enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*24-1:0] req_qpn = '0;
  logic [N-1:0]    req_ready;
  logic            qpn_valid;
  logic [23:0]     qpn_data;
  logic            qpn_ready = 1'b0;
  logic            meta_done = 1'b0;
  logic [CW-1:0]   inflight_cnt;
  logic            credit_err;

  sq_qpn_scheduler #(.REQ_NUM(N), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .sched_enable(sched_enable),
    .req_valid(req_valid), .req_qpn(req_qpn), .req_ready(req_ready),
    .qpn_valid(qpn_valid), .qpn_data(qpn_data), .qpn_ready(qpn_ready),
    .meta_done(meta_done), .inflight_cnt(inflight_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int gnt_q[$];
  int acc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 0;
  int m_data  = 0;
  int m_cnt   = 0;
  bit m_err   = 0;
  int m_ptr   = 0;

  function automatic int qpn_of(input int i);
    return int'(req_qpn[24*i +: 24]);
  endfunction

  // Index that should be granted this cycle, or -1 for no grant.
  function automatic int m_grant_idx();
    if (!rst || !sched_enable) return -1;
    if (m_valid && !qpn_ready) return -1;
    if (m_cnt >= MAXI) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 0;
      m_data  <= 0;
      m_cnt   <= 0;
      m_err   <= 0;
      m_ptr   <= 0;
    end else begin
      if (m_grant_idx() >= 0) begin
        m_valid <= 1;
        m_data  <= qpn_of(m_grant_idx());
        m_ptr   <= (m_grant_idx() + 1) % N;
      end else if (qpn_ready) begin
        m_valid <= 0;
      end
      if (meta_done && m_cnt == 0)
        m_err <= 1;
      else
        m_cnt <= m_cnt + ((m_grant_idx() >= 0) ? 1 : 0) - (meta_done ? 1 : 0);
    end
  end

  // Compare process plus grant / acceptance recording.
  always @(negedge clk) begin
    chk("req_ready", int'(req_ready), (m_grant_idx() >= 0) ? (1 << m_grant_idx()) : 0);
    chk("qpn_valid", int'(qpn_valid), int'(m_valid));
    chk("qpn_data", int'(qpn_data), m_data);
    chk("inflight_cnt", int'(inflight_cnt), m_cnt);
    chk("credit_err", int'(credit_err), int'(m_err));
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) gnt_q.push_back(i);
    if (qpn_valid && qpn_ready) acc_q.push_back(int'(qpn_data));
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_q[$];
    req_qpn      = {24'h000040, 24'h000030, 24'h000020, 24'h000010};
    rst          = 1'b0;
    req_valid    = 4'hF;
    qpn_ready    = 1'b1;
    sched_enable = 1'b1;
    step(3);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_qpn_valid", int'(qpn_valid), 0);
    chk("rst_inflight", int'(inflight_cnt), 0);

    // Release reset: requester 0 wins first, QPN shows up next cycle.
    rst = 1'b1;
    #1;
    chk("first_grant", int'(req_ready), 1);
    gnt_q.delete();
    acc_q.delete();
    step(1);
    chk("first_qpn_valid", int'(qpn_valid), 1);
    chk("first_qpn_data", int'(qpn_data), 'h10);

    // Round robin, then meta_done tied high so the order restarts.
    step(3);
    meta_done = 1'b1;
    step(4);
    req_valid = '0;
    meta_done = 1'b0;
    step(2);
    exp_q = '{'h10, 'h20, 'h30, 'h40, 'h10, 'h20, 'h30, 'h40};
    chk_q("rr_order", acc_q, exp_q);
    chk("rr_inflight", int'(inflight_cnt), 4);
    meta_done = 1'b1;
    step(4);
    meta_done = 1'b0;
    chk("rr_drained", int'(inflight_cnt), 0);

    // Sparse: grant 1 alone to move rr_ptr to 2, then 1 and 3 compete.
    gnt_q.delete();
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b1010;
    step(4);
    req_valid = '0;
    step(1);
    exp_q = '{1, 3, 1, 3, 1};
    chk_q("sparse_order", gnt_q, exp_q);
    meta_done = 1'b1;
    step(5);
    meta_done = 1'b0;
    chk("sparse_drained", int'(inflight_cnt), 0);

    // Credit cap: 8 grants then stall; one credit return allows one grant.
    gnt_q.delete();
    req_valid = 4'hF;
    step(10);
    chk("cap_cnt", int'(inflight_cnt), 8);
    chk("cap_ready", int'(req_ready), 0);
    chk("cap_grants", gnt_q.size(), 8);
    meta_done = 1'b1;
    step(1);
    meta_done = 1'b0;
    chk("cap_after_done_cnt", int'(inflight_cnt), 7);
    chk("cap_after_done_ready", int'(req_ready), 4'b0100);
    step(3);
    chk("cap_refill_cnt", int'(inflight_cnt), 8);
    exp_q = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
    chk_q("cap_order", gnt_q, exp_q);
    req_valid = '0;
    meta_done = 1'b1;
    step(8);
    meta_done = 1'b0;
    chk("cap_drained", int'(inflight_cnt), 0);

    // Backpressure: slot full with qpn_ready low for 5 cycles.
    qpn_ready = 1'b0;
    req_valid = 4'hF;
    step(1);
    step(5);
    chk("bp_valid", int'(qpn_valid), 1);
    chk("bp_data", int'(qpn_data), 'h40);
    chk("bp_ready", int'(req_ready), 0);
    chk("bp_cnt", int'(inflight_cnt), 1);
    qpn_ready = 1'b1;
    #1;
    chk("bp_release_grant", int'(req_ready), 4'b0001);
    step(1);
    chk("bp_next_data", int'(qpn_data), 'h10);
    chk("bp_next_cnt", int'(inflight_cnt), 2);
    req_valid = '0;
    meta_done = 1'b1;
    step(2);
    meta_done = 1'b0;
    chk("bp_drained", int'(inflight_cnt), 0);

    // Credit edges: coincident grant and return, then return at zero.
    req_valid = 4'b0001;
    step(1);
    chk("edge_cnt1", int'(inflight_cnt), 1);
    meta_done = 1'b1;
    step(1);
    chk("edge_coincident", int'(inflight_cnt), 1);
    req_valid = '0;
    step(1);
    chk("edge_cnt0", int'(inflight_cnt), 0);
    chk("edge_err_clear", int'(credit_err), 0);
    step(1);
    meta_done = 1'b0;
    chk("edge_underflow_cnt", int'(inflight_cnt), 0);
    chk("edge_underflow_err", int'(credit_err), 1);
    step(3);
    chk("edge_err_sticky", int'(credit_err), 1);

    // sched_enable low: no grants, but a held QPN still drains.
    qpn_ready = 1'b0;
    req_valid = 4'hF;
    step(1);
    sched_enable = 1'b0;
    step(2);
    chk("dis_valid", int'(qpn_valid), 1);
    chk("dis_data", int'(qpn_data), 'h20);
    chk("dis_ready", int'(req_ready), 0);
    qpn_ready = 1'b1;
    step(1);
    chk("dis_drain_valid", int'(qpn_valid), 0);
    chk("dis_drain_ready", int'(req_ready), 0);

    // Reset mid-operation drops the slot and forgets credits and the error.
    qpn_ready = 1'b0;
    sched_enable = 1'b1;
    step(1);
    chk("mid_pre_valid", int'(qpn_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(qpn_valid), 0);
    chk("mid_rst_data", int'(qpn_data), 0);
    chk("mid_rst_cnt", int'(inflight_cnt), 0);
    chk("mid_rst_err", int'(credit_err), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    step(2);
    req_valid = '0;
    rst = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
